// File: rtl/profile_engine.sv
// profile_engine: per-channel jerk/accel/velocity integrator with a host
// register file and a packed speed output.
// Optional feature: define PROFILE_ENGINE_CLAMP_EN to clamp V_OUT at TARGET_V
// for channels with STATUS[1] set (STATUS[2] flags that a clamp happened).
module profile_engine #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 64,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     acc_step,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic [NUM_CH*DATA_W-1:0] speed,
  input  logic [CH_W+2:0]          param_addr,
  input  logic [31:0]              param_in,
  input  logic                     param_write_lo,
  input  logic                     param_write_hi,
  output logic [DATA_W-1:0]        param_out
);

  localparam int AW    = CH_W + 3;
  localparam int DEPTH = 1 << AW;

  localparam logic [2:0] R_STATUS = 3'd0;
  localparam logic [2:0] R_VEFF   = 3'd1;
  localparam logic [2:0] R_VIN    = 3'd2;
  localparam logic [2:0] R_VOUT   = 3'd3;
  localparam logic [2:0] R_A      = 3'd4;
  localparam logic [2:0] R_J      = 3'd5;
  localparam logic [2:0] R_JJ     = 3'd6;
  localparam logic [2:0] R_TGT    = 3'd7;

  typedef enum logic [2:0] {IDLE, RD_STATUS, CHK_STATUS, INTEGRATE, NEXT} state_t;

  // Register file: {channel, reg} addressed, no reset (contents survive rst_n).
  logic signed [DATA_W-1:0] ram_q [DEPTH];
  logic [AW-1:0]            addr_q;

  // Control state
  state_t                   state_q;
  logic [CH_W-1:0]          ch_q;
  logic [2:0]               step_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     overrun_q;
  logic [NUM_CH*DATA_W-1:0] speed_q;

  // Per-channel values captured during a channel's processing
  logic                     stat_en_q;
  logic signed [DATA_W-1:0] vold_q;
  logic                     clamp_q;

  // Engine write port and current-channel operand taps
  logic                     eng_we;
  logic [2:0]               eng_reg;
  logic signed [DATA_W-1:0] eng_wdata;
  logic [AW-1:0]            eng_addr;
  logic                     host_ok;
  logic signed [DATA_W-1:0] cur_j, cur_jj, cur_a, cur_vout;
  logic signed [DATA_W-1:0] vout_sum, vout_new, veff;
  logic                     clamp_hit;

  // Two's-complement add that wraps modulo 2^DATA_W.
  function automatic logic signed [DATA_W-1:0] wrap_add(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    return a + b;
  endfunction

  // Arithmetic halving (rounds toward minus infinity).
  function automatic logic signed [DATA_W-1:0] halve(input logic signed [DATA_W-1:0] s);
    return s >>> 1;
  endfunction

  assign cur_j    = ram_q[{ch_q, R_J}];
  assign cur_jj   = ram_q[{ch_q, R_JJ}];
  assign cur_a    = ram_q[{ch_q, R_A}];
  assign cur_vout = ram_q[{ch_q, R_VOUT}];

  // At step 3 cur_a already holds A_new and cur_vout still holds V_OUT_old.
  assign vout_sum = wrap_add(cur_vout, cur_a);

`ifdef PROFILE_ENGINE_CLAMP_EN
  localparam logic signed [DATA_W-1:0] CLAMPED_FLAG = {{(DATA_W-3){1'b0}}, 3'b100};

  logic                     stat_clamp_q;
  logic signed [DATA_W-1:0] cur_tgt, cur_status;

  // Target reached in the direction of travel; a zero acceleration never clamps.
  function automatic logic at_target(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] v,
                                     input logic signed [DATA_W-1:0] t);
    logic a_pos, a_neg;
    a_neg = a[DATA_W-1];
    a_pos = !a[DATA_W-1] && (a != '0);
    return (a_pos && (v >= t)) || (a_neg && (v <= t));
  endfunction

  assign cur_tgt    = ram_q[{ch_q, R_TGT}];
  assign cur_status = ram_q[{ch_q, R_STATUS}];
  assign clamp_hit  = stat_clamp_q && at_target(cur_a, vout_sum, cur_tgt);
  assign vout_new   = clamp_hit ? cur_tgt : vout_sum;
`else
  assign clamp_hit  = 1'b0;
  assign vout_new   = vout_sum;
`endif

  // At step 4 cur_vout holds the (possibly clamped) V_OUT_new.
  assign veff = halve(wrap_add(vold_q, cur_vout));

  // Engine write selection: one register per INTEGRATE step, in dependency order.
  always_comb begin
    eng_we    = 1'b0;
    eng_reg   = R_STATUS;
    eng_wdata = '0;
    if (state_q == INTEGRATE) begin
      eng_we = 1'b1;
      case (step_q)
        3'd0: begin eng_reg = R_J;    eng_wdata = wrap_add(cur_j, cur_jj); end
        3'd1: begin eng_reg = R_A;    eng_wdata = wrap_add(cur_a, cur_j);  end
        3'd2: begin eng_reg = R_VIN;  eng_wdata = cur_vout;                end
        3'd3: begin eng_reg = R_VOUT; eng_wdata = vout_new;                end
        3'd4: begin eng_reg = R_VEFF; eng_wdata = veff;                    end
`ifdef PROFILE_ENGINE_CLAMP_EN
        3'd5: begin eng_reg = R_A;    eng_wdata = '0;                      end
        3'd6: begin eng_reg = R_J;    eng_wdata = '0;                      end
        default: begin eng_reg = R_STATUS; eng_wdata = cur_status | CLAMPED_FLAG; end
`else
        default: eng_we = 1'b0;
`endif
      endcase
    end
  end

  assign eng_addr = {ch_q, eng_reg};
  // A host write colliding with an engine write to the same register is dropped.
  assign host_ok  = !(eng_we && (eng_addr == param_addr));

  // Register file writes (host halves, engine full word) and read-address register.
  always_ff @(posedge clk) begin
    if (param_write_lo && host_ok) ram_q[param_addr][31:0]       <= param_in;
    if (param_write_hi && host_ok) ram_q[param_addr][DATA_W-1:32] <= param_in[DATA_W-33:0];
    if (eng_we)                    ram_q[eng_addr]                <= eng_wdata;
    addr_q <= param_addr;
  end

  assign param_out = ram_q[addr_q];

  // Capture channel enable/clamp bits and V_OUT_old for the later V_EFF step.
  always_ff @(posedge clk) begin
    if (state_q == RD_STATUS) begin
      stat_en_q <= ram_q[{ch_q, R_STATUS}][0];
`ifdef PROFILE_ENGINE_CLAMP_EN
      stat_clamp_q <= ram_q[{ch_q, R_STATUS}][1];
`endif
    end
    if ((state_q == INTEGRATE) && (step_q == 3'd3)) begin
      vold_q  <= cur_vout;
      clamp_q <= clamp_hit;
    end
  end

  // Pass sequencer with registered busy/done/overrun and speed outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      speed_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= acc_step && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (acc_step) begin
            state_q <= RD_STATUS;
            ch_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        RD_STATUS: state_q <= CHK_STATUS;
        CHK_STATUS: begin
          step_q  <= '0;
          state_q <= stat_en_q ? INTEGRATE : NEXT;
        end
        INTEGRATE: begin
          if (step_q == 3'd4) speed_q[int'(ch_q)*DATA_W +: DATA_W] <= veff;
          if (((step_q == 3'd4) && !clamp_q) || (step_q == 3'd7)) state_q <= NEXT;
          else                                                    step_q  <= step_q + 3'd1;
        end
        NEXT: begin
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= RD_STATUS;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;
  assign speed   = speed_q;

endmodule

// File: tb/tb_profile_engine.sv
// tb_profile_engine: directed tests for profile_engine (NUM_CH=8, DATA_W=64).
module tb_profile_engine;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 64;
  localparam int CH_W   = 3;

  localparam logic [2:0] R_STATUS = 3'd0;
  localparam logic [2:0] R_VEFF   = 3'd1;
  localparam logic [2:0] R_VIN    = 3'd2;
  localparam logic [2:0] R_VOUT   = 3'd3;
  localparam logic [2:0] R_A      = 3'd4;
  localparam logic [2:0] R_J      = 3'd5;
  localparam logic [2:0] R_JJ     = 3'd6;
  localparam logic [2:0] R_TGT    = 3'd7;

`ifdef PROFILE_ENGINE_CLAMP_EN
  localparam logic [63:0] CL_VOUT = 64'd100, CL_A = 64'd0, CL_STAT = 64'd7, CL_SPD = 64'd97;
`else
  localparam logic [63:0] CL_VOUT = 64'd105, CL_A = 64'd10, CL_STAT = 64'd3, CL_SPD = 64'd100;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     acc_step = 1'b0;
  logic                     busy, done, overrun;
  logic [NUM_CH*DATA_W-1:0] speed;
  logic [CH_W+2:0]          param_addr = '0;
  logic [31:0]              param_in = '0;
  logic                     param_write_lo = 1'b0;
  logic                     param_write_hi = 1'b0;
  logic [DATA_W-1:0]        param_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_speed [NUM_CH];

  always #5 clk = ~clk;

  profile_engine #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .acc_step(acc_step), .busy(busy), .done(done),
    .overrun(overrun), .speed(speed), .param_addr(param_addr), .param_in(param_in),
    .param_write_lo(param_write_lo), .param_write_hi(param_write_hi), .param_out(param_out)
  );

  task automatic wr(input int ch, input logic [2:0] r, input logic [63:0] v);
    param_addr = {3'(ch), r};
    param_in = v[31:0];  param_write_lo = 1'b1;
    @(posedge clk); #1;
    param_write_lo = 1'b0; param_in = v[63:32]; param_write_hi = 1'b1;
    @(posedge clk); #1;
    param_write_hi = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [2:0] r, output logic [63:0] v);
    param_addr = {3'(ch), r};
    @(posedge clk); #1;
    v = param_out;
  endtask

  function automatic logic [63:0] spd(input int c);
    return speed[c*DATA_W +: DATA_W];
  endfunction

  task automatic run_pass(output int cyc, output int dn);
    cyc = 0; dn = 0;
    acc_step = 1'b1;
    @(posedge clk); #1;
    acc_step = 1'b0;
    while (busy && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (done) dn++;
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pass_timeout: busy=%b after %0d cycles, required 0", busy, cyc); end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_cmp++; if (speed !== '0)     begin n_bad++; $display("FAIL rst_speed: got %h want 0", speed); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_speed[c] = 64'd0;
      for (int r = 0; r < 8; r++) wr(c, 3'(r), 64'd0);
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_after_release: busy=%b want 0", busy); end
  endtask

  task automatic test_read_latency();
    logic [63:0] v;
    wr(0, R_TGT, 64'h1111);
    wr(1, R_TGT, 64'h2222_0000_3333);
    rd(0, R_TGT, v);
    n_cmp++; if (v !== 64'h1111) begin n_bad++; $display("FAIL rd_first: got %h want 1111", v); end
    param_addr = {3'd1, R_TGT};
    #2;
    n_cmp++; if (param_out !== 64'h1111) begin n_bad++; $display("FAIL rd_latency_hold: got %h want 1111", param_out); end
    @(posedge clk); #1;
    n_cmp++; if (param_out !== 64'h2222_0000_3333) begin n_bad++; $display("FAIL rd_latency_new: got %h want 222200003333", param_out); end
  endtask

  task automatic test_basic();
    logic [63:0] v; int cyc, dn;
    wr(0, R_A, 64'd5); wr(0, R_VOUT, 64'd100); wr(0, R_STATUS, 64'd1);
    run_pass(cyc, dn);
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", dn); end
    rd(0, R_VIN, v);  n_cmp++; if (v !== 64'd100) begin n_bad++; $display("FAIL basic_vin: got %0d want 100", v); end
    rd(0, R_VOUT, v); n_cmp++; if (v !== 64'd105) begin n_bad++; $display("FAIL basic_vout: got %0d want 105", v); end
    rd(0, R_VEFF, v); n_cmp++; if (v !== 64'd102) begin n_bad++; $display("FAIL basic_veff: got %0d want 102", v); end
    rd(0, R_A, v);    n_cmp++; if (v !== 64'd5)   begin n_bad++; $display("FAIL basic_a: got %0d want 5", v); end
    n_cmp++; if (spd(0) !== 64'd102) begin n_bad++; $display("FAIL basic_speed0: got %0d want 102", spd(0)); end
    n_cmp++; if (spd(1) !== 64'd0)   begin n_bad++; $display("FAIL basic_speed1: got %0d want 0", spd(1)); end
    exp_speed[0] = 64'd102;
    wr(0, R_STATUS, 64'd0);
  endtask

  task automatic test_two_pass();
    logic [63:0] v; int cyc, dn;
    wr(3, R_JJ, 64'd1); wr(3, R_J, 64'd2); wr(3, R_STATUS, 64'd1);
    run_pass(cyc, dn);
    rd(3, R_VOUT, v); n_cmp++; if (v !== 64'd3) begin n_bad++; $display("FAIL two_p1_vout: got %0d want 3", v); end
    rd(3, R_VEFF, v); n_cmp++; if (v !== 64'd1) begin n_bad++; $display("FAIL two_p1_veff: got %0d want 1", v); end
    run_pass(cyc, dn);
    rd(3, R_J, v);    n_cmp++; if (v !== 64'd4)  begin n_bad++; $display("FAIL two_j: got %0d want 4", v); end
    rd(3, R_A, v);    n_cmp++; if (v !== 64'd7)  begin n_bad++; $display("FAIL two_a: got %0d want 7", v); end
    rd(3, R_VIN, v);  n_cmp++; if (v !== 64'd3)  begin n_bad++; $display("FAIL two_vin: got %0d want 3", v); end
    rd(3, R_VOUT, v); n_cmp++; if (v !== 64'd10) begin n_bad++; $display("FAIL two_vout: got %0d want 10", v); end
    n_cmp++; if (spd(3) !== 64'd6)   begin n_bad++; $display("FAIL two_speed3: got %0d want 6", spd(3)); end
    n_cmp++; if (spd(0) !== 64'd102) begin n_bad++; $display("FAIL two_speed0_kept: got %0d want 102", spd(0)); end
    exp_speed[3] = 64'd6;
    wr(3, R_STATUS, 64'd0);
  endtask

  task automatic test_wrap();
    logic [63:0] v; int cyc, dn;
    wr(1, R_A, 64'd1); wr(1, R_VOUT, 64'h7FFF_FFFF_FFFF_FFFF); wr(1, R_STATUS, 64'd1);
    wr(2, R_A, 64'hFFFF_FFFF_FFFF_FFFD); wr(2, R_VOUT, 64'hFFFF_FFFF_FFFF_FFFC); wr(2, R_STATUS, 64'd1);
    run_pass(cyc, dn);
    rd(1, R_VOUT, v); n_cmp++; if (v !== 64'h8000_0000_0000_0000) begin n_bad++; $display("FAIL wrap_vout: got %h want 8000000000000000", v); end
    rd(1, R_VEFF, v); n_cmp++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL wrap_veff: got %h want ffffffffffffffff", v); end
    rd(2, R_VOUT, v); n_cmp++; if (v !== 64'hFFFF_FFFF_FFFF_FFF9) begin n_bad++; $display("FAIL neg_vout: got %h want fffffffffffffff9", v); end
    n_cmp++; if (spd(2) !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_bad++; $display("FAIL neg_speed2: got %h want fffffffffffffffa", spd(2)); end
    n_cmp++; if (spd(1) !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL wrap_speed1: got %h want ffffffffffffffff", spd(1)); end
    exp_speed[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_speed[2] = 64'hFFFF_FFFF_FFFF_FFFA;
    wr(1, R_STATUS, 64'd0); wr(2, R_STATUS, 64'd0);
  endtask

  task automatic test_clamp();
    logic [63:0] v; int cyc, dn;
    wr(7, R_A, 64'd10); wr(7, R_VOUT, 64'd95); wr(7, R_TGT, 64'd100); wr(7, R_STATUS, 64'd3);
    run_pass(cyc, dn);
    rd(7, R_VOUT, v);   n_cmp++; if (v !== CL_VOUT) begin n_bad++; $display("FAIL clamp_vout: got %0d want %0d", v, CL_VOUT); end
    rd(7, R_A, v);      n_cmp++; if (v !== CL_A)    begin n_bad++; $display("FAIL clamp_a: got %0d want %0d", v, CL_A); end
    rd(7, R_J, v);      n_cmp++; if (v !== 64'd0)   begin n_bad++; $display("FAIL clamp_j: got %0d want 0", v); end
    rd(7, R_STATUS, v); n_cmp++; if (v !== CL_STAT) begin n_bad++; $display("FAIL clamp_status: got %0d want %0d", v, CL_STAT); end
    n_cmp++; if (spd(7) !== CL_SPD) begin n_bad++; $display("FAIL clamp_speed7: got %0d want %0d", spd(7), CL_SPD); end
    exp_speed[7] = CL_SPD;
    wr(7, R_STATUS, 64'd0);
  endtask

  task automatic test_overrun();
    logic [63:0] v; int cyc, dn, ov;
    wr(5, R_A, 64'd2); wr(5, R_VOUT, 64'd10); wr(5, R_STATUS, 64'd1);
    ov = 0; dn = 0; cyc = 0;
    acc_step = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (overrun) ov++;
      if (done) dn++;
    end
    acc_step = 1'b0;
    while (busy && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (overrun) ov++;
      if (done) dn++;
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovr_timeout: busy=%b want 0", busy); end
    n_cmp++; if (ov !== 3) begin n_bad++; $display("FAIL ovr_count: got %0d want 3", ov); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL ovr_done_count: got %0d want 1", dn); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovr_no_restart: busy=%b want 0", busy); end
    rd(5, R_VOUT, v); n_cmp++; if (v !== 64'd12) begin n_bad++; $display("FAIL ovr_vout: got %0d want 12", v); end
    n_cmp++; if (spd(5) !== 64'd11) begin n_bad++; $display("FAIL ovr_speed5: got %0d want 11", spd(5)); end
    exp_speed[5] = 64'd11;
    wr(5, R_STATUS, 64'd0);
  endtask

  task automatic test_disabled();
    logic [63:0] v; int cyc, dn;
    run_pass(cyc, dn);
    n_cmp++; if (cyc > 3*NUM_CH) begin n_bad++; $display("FAIL dis_busy_cycles: got %0d want <= %0d", cyc, 3*NUM_CH); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL dis_done_count: got %0d want 1", dn); end
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (spd(c) !== exp_speed[c]) begin n_bad++; $display("FAIL dis_speed%0d: got %h want %h", c, spd(c), exp_speed[c]); end
    end
    rd(3, R_VOUT, v); n_cmp++; if (v !== 64'd10) begin n_bad++; $display("FAIL dis_ram_ch3: got %0d want 10", v); end
    rd(5, R_VOUT, v); n_cmp++; if (v !== 64'd12) begin n_bad++; $display("FAIL dis_ram_ch5: got %0d want 12", v); end
  endtask

  task automatic test_reset_mid_pass();
    logic [63:0] v; int cyc, dn;
    wr(6, R_A, 64'd4); wr(6, R_VOUT, 64'd20); wr(6, R_STATUS, 64'd1);
    acc_step = 1'b1;
    @(posedge clk); #1;
    acc_step = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_cmp++; if (speed !== '0)  begin n_bad++; $display("FAIL mid_rst_speed: got %h want 0", speed); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_idle: busy=%b want 0", busy); end
    rd(3, R_VOUT, v); n_cmp++; if (v !== 64'd10) begin n_bad++; $display("FAIL mid_rst_ram_kept: got %0d want 10", v); end
    run_pass(cyc, dn);
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL mid_rst_done_count: got %0d want 1", dn); end
    rd(6, R_VOUT, v); n_cmp++; if (v !== 64'd24) begin n_bad++; $display("FAIL mid_rst_vout6: got %0d want 24", v); end
    n_cmp++; if (spd(6) !== 64'd22) begin n_bad++; $display("FAIL mid_rst_speed6: got %0d want 22", spd(6)); end
    n_cmp++; if (spd(0) !== 64'd0)  begin n_bad++; $display("FAIL mid_rst_speed0: got %0d want 0", spd(0)); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_basic();
    test_two_pass();
    test_wrap();
    test_clamp();
    test_overrun();
    test_disabled();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/profile_engine.md
PROFILE_ENGINE -- requirements
Module: profile_engine

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, channel count, legal range 1..16.
REQ-002 SHALL have parameter DATA_W, default 64, per-register and speed width, legal range 33..64.
REQ-003 SHALL have parameter CH_W, default $clog2(NUM_CH) with minimum 1, channel index width (derived; never overridden).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous active-low.
REQ-006 SHALL have port acc_step  input  1  single-cycle pulse starting one integration pass.
REQ-007 SHALL have port busy  output  1  high while a pass is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse on the cycle busy falls.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when acc_step arrives while busy.
REQ-010 SHALL have port speed  output  NUM_CH*DATA_W  flat vector; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-011 SHALL have port param_addr  input  CH_W+3  host address {channel, reg}.
REQ-012 SHALL have port param_in  input  32  host write data.
REQ-013 SHALL have port param_write_lo  input  1  write param_in into bits [31:0].
REQ-014 SHALL have port param_write_hi  input  1  write param_in[DATA_W-33:0] into bits [DATA_W-1:32].
REQ-015 SHALL have port param_out  output  DATA_W  host read data.

Function
REQ-016 SHALL hold 8 signed DATA_W registers per channel: 0 STATUS, 1 V_EFF, 2 V_IN, 3 V_OUT, 4 A, 5 J, 6 JJ, 7 TARGET_V.
REQ-017 SHALL present param_out one cycle after param_addr, as a registered-address read.
REQ-018 SHALL give the engine write priority when engine and host write the same address in the same cycle; the host write is dropped.
REQ-019 SHALL use FSM states IDLE, RD_STATUS, CHK_STATUS, INTEGRATE (multi-cycle), NEXT; acc_step in IDLE -> RD_STATUS with channel 0 and busy=1.
REQ-020 SHALL skip a channel whose STATUS[0]=0 with no register or speed change, within at most 3 cycles.
REQ-021 SHALL for an enabled channel execute in order: J<=J+JJ; A<=A+J_new; V_IN<=V_OUT_old; V_OUT<=V_OUT_old+A_new; V_EFF<=(V_OUT_old+V_OUT_new)>>>1 (arithmetic); speed[c]<=V_EFF.
REQ-022 SHALL complete an enabled channel in at most 24 cycles.
REQ-023 SHALL perform all adds modulo 2^DATA_W, two's-complement wrap, no saturation (except REQ-031).
REQ-024 SHALL after channel NUM_CH-1 return to IDLE, drop busy and pulse done; channel index SHALL NOT wrap past NUM_CH-1.
REQ-025 SHALL ignore acc_step while busy (no restart, no queuing) and pulse overrun for each such cycle.
REQ-026 SHALL accept host writes at any time; values written during a pass take effect if written before the engine reads them.

Reset
REQ-027 SHALL on rst_n low immediately force IDLE, channel=0, busy=0, done=0, overrun=0, speed=0.
REQ-028 SHALL NOT clear register RAM on reset; reset mid-pass leaves already-written registers as written.
REQ-029 SHALL leave the engine in IDLE after reset release until the next acc_step.

Configuration
REQ-030 SHALL support macro PROFILE_ENGINE_CLAMP_EN.
REQ-031 With the macro defined and STATUS[1]=1: if A_new>0 and V_OUT_new>=TARGET_V, or A_new<0 and V_OUT_new<=TARGET_V, V_OUT SHALL be written TARGET_V, A and J written 0, STATUS[2] set; V_EFF uses the clamped V_OUT.
REQ-032 Without the macro, STATUS[1] and TARGET_V SHALL be ignored and STATUS SHALL never be written by the engine.

Verification
REQ-033 Ch0 enabled, JJ=0, J=0, A=5, V_OUT=100; one acc_step -> V_IN=100, V_OUT=105, V_EFF=102, speed[0]=102, done pulses once.
REQ-034 Ch3 enabled, JJ=1, J=2, A=0, V_OUT=0; two passes -> J=4, A=7, V_OUT=10, speed[3]=(3+10)>>>1=6.
REQ-035 All channels disabled; acc_step -> busy ≤3*NUM_CH cycles, all speed and RAM unchanged.
REQ-036 acc_step repeated while busy -> overrun pulse per repeat; single pass result unchanged.
REQ-037 CLAMP_EN, STATUS=3, A=10, V_OUT=95, TARGET_V=100 -> V_OUT=100, A=0, J=0, STATUS=7, speed=97; without macro -> V_OUT=105, speed=100.
REQ-038 rst_n asserted mid-pass -> busy and speed 0 same cycle; next acc_step completes a normal pass.
